// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM state codes and stream framing sizes.
package imem_loader_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four stream bytes into one little-endian 32-bit word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d = 2'd0;
    end else if (byte_en) begin
      word_d[8*cnt_q +: 8] = byte_in;
      cnt_d                = cnt_q + 2'd1;
    end
  end

  // The counter wraps to 0 on the fourth byte, ready for the next word.
  assign word_full = byte_en && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_out  = word_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a length-prefixed byte stream while holding the core in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

  logic [2:0]        state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              xfer;
  logic              pk_clear, pk_en, pk_full;
  logic [31:0]       pk_word;
  logic [15:0]       len_full;
  logic [15:0]       idx_next;
  logic [ADDR_W-1:0] wr_addr;

  imem_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .byte_en   (pk_en),
    .byte_in   (in_data),
    .word_out  (pk_word),
    .word_full (pk_full)
  );

  // in_ready comes from state alone so it never combinationally follows in_valid.
  assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
  assign xfer     = in_valid && in_ready;
  assign len_full = {in_data, count_q[7:0]};
  assign idx_next = 16'(idx_q) + 16'd1;
  assign wr_addr  = ADDR_W'(idx_q) << 2;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    error_d  = error_q;
    pk_clear = 1'b0;
    pk_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LEN_LO;
          error_d  = 1'b0;
          idx_d    = '0;
          pk_clear = 1'b1;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          count_d = {8'h00, in_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          count_d = len_full;
          if (len_full == 16'd0) begin
            state_d = S_DONE;
          end else if (len_full > 16'(DEPTH_WORDS)) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          pk_en = 1'b1;
          if (pk_full) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_next == count_q) ? S_DONE : S_DATA;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= 16'd0;
      idx_q   <= '0;
      error_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      error_q <= error_d;
      if (state_q == S_WRITE) begin
        addr_q  <= wr_addr;
        wdata_q <= pk_word;
      end
    end
  end

  // Address and data show the live word during WRITE and hold it afterwards.
  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = imem_we ? wr_addr : addr_q;
  assign imem_wdata = imem_we ? pk_word : wdata_q;
  assign busy       = (state_q != S_IDLE);
  assign core_hold  = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized loads against a stream-level model.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, imem_we, core_hold, busy, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_data[$];
  int            done_cnt = 0;
  bit            prev_done = 1'b0;

  imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_done) chk("hold_after_done", {62'd0, core_hold, busy}, 64'd0);
    if (done) begin
      done_cnt++;
      chk("hold_during_done", {63'd0, core_hold}, 64'd1);
    end
    prev_done = done;
    if (imem_we) begin
      obs_addr.push_back(imem_addr);
      obs_data.push_back(imem_wdata);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_start);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    if (with_start) start = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Model: header is N little-endian, words sent LSB first; legal N gives writes at 4*i.
  task automatic run_load(input string tag, input int n, input logic [31:0] words[$],
                          input int maxgap, input int start_at);
    logic [7:0] bq[$];
    int st, dc, t;
    bit legal;
    legal = (n <= DEPTH);
    bq.push_back(8'(n));
    bq.push_back(8'(n >> 8));
    if (legal)
      foreach (words[i])
        for (int k = 0; k < 4; k++) bq.push_back(words[i][8*k +: 8]);
    st = obs_addr.size();
    dc = done_cnt;
    pulse_start();
    chk({tag, "_err_clr"}, {63'd0, error}, 64'd0);
    chk({tag, "_hold"}, {62'd0, core_hold, busy}, 64'd3);
    foreach (bq[i]) begin
      send_byte(bq[i], (i == start_at));
      if (i >= 2 && legal) chk({tag, "_stall_ready"}, {63'd0, in_ready || imem_we}, 64'd1);
      repeat ($urandom_range(maxgap, 0)) @(negedge clk);
    end
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle"}, {62'd0, busy, core_hold}, 64'd0);
    chk({tag, "_nwr"}, 64'(obs_addr.size() - st), legal ? 64'(n) : 64'd0);
    for (int i = 0; i < n && legal && st + i < obs_addr.size(); i++) begin
      chk({tag, "_addr"}, obs_addr[st+i], 64'(4 * i));
      chk({tag, "_data"}, 64'(obs_data[st+i]), 64'(words[i]));
    end
    chk({tag, "_done"}, 64'(done_cnt - dc), legal ? 64'd1 : 64'd0);
    chk({tag, "_error"}, {63'd0, error}, legal ? 64'd0 : 64'd1);
  endtask

  initial begin
    logic [31:0] w[$];
    int st, n;
    repeat (3) @(negedge clk);
    chk("reset_outs", {in_ready, imem_we, core_hold, busy, done, error, imem_addr[57:0]}, 64'd0);
    chk("reset_wdata", 64'(imem_wdata), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    w = '{32'h00500093, 32'h00308113};
    run_load("basic", 2, w, 0, -1);
    run_load("stall", 2, w, 3, -1);
    w = '{};
    run_load("zero", 0, w, 0, -1);
    run_load("oversize", 65, w, 0, -1);
    w = '{32'hCAFEF00D};
    run_load("after_err", 1, w, 0, -1);
    w = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    run_load("busy_start", 3, w, 1, 5);

    // Abort a load two bytes into its only word.
    st = obs_addr.size();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_outs", {in_ready, imem_we, core_hold, busy, done, error, imem_addr[57:0]}, 64'd0);
    chk("midreset_wdata", 64'(imem_wdata), 64'd0);
    chk("midreset_nwr", 64'(obs_addr.size() - st), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    w = '{32'h0DEADBEE};
    run_load("post_reset", 1, w, 1, -1);

    w = '{};
    for (int i = 0; i < DEPTH; i++) w.push_back(32'(i));
    run_load("full", DEPTH, w, 0, -1);
    chk("full_last_addr", obs_addr[obs_addr.size()-1], 64'd252);
    chk("full_last_data", 64'(obs_data[obs_data.size()-1]), 64'h3F);

    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(6, 1);
      if (r == 5) n = DEPTH + $urandom_range(200, 1);
      w = '{};
      for (int i = 0; i < n && n <= DEPTH; i++) w.push_back($urandom);
      run_load("rand", n, w, 2, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: the processor core only reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and packs it into 32-bit little-endian instruction words.
- Writes the words into instruction memory at byte addresses 0, 4, 8, and so on.
- Holds the core in reset (core_hold) for the whole load, then releases it so execution starts at PC 0.

Parameters:
- DEPTH_WORDS, 64, instruction-memory capacity in 32-bit words; the largest legal load count.
- ADDR_W, 64, width of imem_addr; matches the processor PC width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE.
- in_valid  input  1  a byte is present on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  the loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  ADDR_W  byte address of the word being written; always a multiple of 4.
- imem_wdata  output  32  instruction word being written.
- core_hold  output  1  while 1, the core's reset is asserted externally.
- busy  output  1  the loader is not in IDLE.
- done  output  1  one-cycle pulse when a load completes successfully.
- error  output  1  sticky flag: the last load was rejected; cleared by the next accepted start.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE.
  - All outputs 0: in_ready, imem_we, imem_addr, imem_wdata, core_hold, busy, done, error.
  - Word count, word index and byte counter are cleared.
  - A reset in the middle of a load aborts it. Words already written stay in memory; there is no partial-word write.
- Stream format, after start: LEN_LO, LEN_HI (a 16-bit word count N, little-endian), then N×4 data bytes. Each word is sent least-significant byte first.
- States:
  - IDLE: in_ready=0, core_hold=0. On start=1 → LEN_LO; clear error, word index and byte counter; core_hold=1 from the next cycle.
  - LEN_LO: in_ready=1. On a transfer, capture count[7:0] → LEN_HI.
  - LEN_HI: in_ready=1. On a transfer, capture count[15:8] and go by case:
    - N==0 → DONE.
    - N>DEPTH_WORDS → set error → IDLE, with no writes and no done pulse.
    - otherwise → DATA.
  - DATA: in_ready=1. Each transfer shifts the byte into word bits [8k+7:8k], where k is the byte counter 0..3. On the 4th byte → WRITE.
  - WRITE: in_ready=0; imem_we=1; imem_addr=index×4; imem_wdata=the assembled word. Then index increments; if index+1==N → DONE, else → DATA with the byte counter at 0.
  - DONE: done=1 for exactly one cycle, core_hold still 1 → IDLE, where core_hold=0.
- Latency and handshake:
  - Best case is 5 cycles per word (4 byte transfers plus 1 WRITE).
  - Cycles with in_valid=0 stall the loader without any state change.
  - in_ready must not depend combinationally on in_valid.
- start while busy is ignored and has no effect.
- imem_we is only ever 1 in WRITE; at every other time imem_addr and imem_wdata hold their last values.
- busy=1 in every state except IDLE. core_hold=1 in every state except IDLE.
- Index arithmetic: the index is wide enough to hold DEPTH_WORDS; imem_addr is the index zero-extended to ADDR_W and shifted left by 2. Addresses never wrap because N≤DEPTH_WORDS is enforced.

Decomposition:
- Shared package (imem_loader_pkg): state enumeration (IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE), BYTES_PER_WORD=4, LEN_BYTES=2.
- One sub-module, imem_word_packer:
  - Contains the byte counter and the 32-bit shift/insert register.
  - Inputs: clk, reset, clear, byte_en, byte_in[7:0].
  - Outputs: word_out[31:0], word_full.
  - The top-level FSM drives clear and byte_en.

Test Plan:
- Basic load, DEPTH_WORDS=64: pulse start, then bytes 02 00 93 00 50 00 13 81 30 00 with in_valid held high.
  - Required: write addr 0 data 0x00500093, then write addr 4 data 0x00308113.
  - done pulses once; core_hold falls the cycle after done; no other imem_we.
- Stall tolerance: same stream with in_valid low for 3 cycles between every byte.
  - Required: identical writes and data; in_ready stays 1 throughout DATA; no extra writes.
- Zero-length and oversize loads:
  - Bytes 00 00 → done pulses, no imem_we, error=0.
  - Bytes 41 00 (N=65) → error=1, no done, returns to IDLE, core_hold=0.
  - A following valid load clears error at start.
- Reset mid-word: load N=1, send 2 data bytes, then drive reset low for 1 cycle.
  - Required: all outputs 0, no imem_we, state IDLE.
  - A fresh load afterwards writes the correct word to addr 0.
- Start while busy: pulse start again during DATA.
  - Required: no restart; the byte sequence and write addresses are unaffected.
- Full-depth load: N=64 with incrementing words 0x00000000..0x0000003F.
  - Required: last write at addr 252 data 0x0000003F, then done.
